// File: rtl/harv_dmem_wb_bridge_if.sv
// Core-side dmem request/grant bundle and Wishbone B3 classic bundle.
// Signal names are given from the bridge's point of view.
interface harv_dmem_if;
  logic        dmem_req_i;
  logic        dmem_wren_i;
  logic [1:0]  dmem_ben_i;
  logic        dmem_usgn_i;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_wdata_i;
  logic        dmem_gnt_o;
  logic        dmem_err_o;
  logic [31:0] dmem_rdata_o;

  modport master (
    output dmem_req_i, dmem_wren_i, dmem_ben_i, dmem_usgn_i, dmem_addr_i, dmem_wdata_i,
    input  dmem_gnt_o, dmem_err_o, dmem_rdata_o
  );
  modport slave (
    input  dmem_req_i, dmem_wren_i, dmem_ben_i, dmem_usgn_i, dmem_addr_i, dmem_wdata_i,
    output dmem_gnt_o, dmem_err_o, dmem_rdata_o
  );
endinterface

interface harv_wb_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );
  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/harv_dmem_wb_bridge.sv
// harv dmem port to Wishbone B3 classic bridge: lane steering, load extension,
// misalignment and bus-timeout errors. One transfer outstanding at a time.
module harv_dmem_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  harv_dmem_if.slave  dmem,
  harv_wb_if.master   wb
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int unsigned CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  state_t         state_q, state_d;
  logic           wren_q, usgn_q, err_q;
  logic [1:0]     ben_q;
  logic [31:0]    addr_q, dat_q, rdat_q;
  logic [3:0]     sel_q;
  logic [CW-1:0]  cnt_q;

  logic [3:0]     sel_d;
  logic [31:0]    dat_d;
  logic           misalign;
  logic           timeout;
  logic           in_bus;

  always_comb begin
    sel_d = 4'b0000;
    dat_d = 32'h0;
    case (dmem.dmem_ben_i)
      2'b00: begin
        sel_d = 4'b0001 << dmem.dmem_addr_i[1:0];
        dat_d = {4{dmem.dmem_wdata_i[7:0]}};
      end
      2'b01: begin
        sel_d = dmem.dmem_addr_i[1] ? 4'b1100 : 4'b0011;
        dat_d = {2{dmem.dmem_wdata_i[15:0]}};
      end
      2'b10: begin
        sel_d = 4'b1111;
        dat_d = dmem.dmem_wdata_i;
      end
      default: begin
        sel_d = 4'b0000;
        dat_d = 32'h0;
      end
    endcase
  end

  assign misalign = (dmem.dmem_ben_i == 2'b11)
                  | ((dmem.dmem_ben_i == 2'b01) & dmem.dmem_addr_i[0])
                  | ((dmem.dmem_ben_i == 2'b10) & (dmem.dmem_addr_i[1:0] != 2'b00));

  assign timeout = TO_EN && (cnt_q == TO_LIMIT);
  assign in_bus  = (state_q == BUS);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dmem.dmem_req_i) state_d = misalign ? RESP : BUS;
      BUS:  if (wb.wb_ack_i || wb.wb_err_i || timeout) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wren_q <= 1'b0;
      usgn_q <= 1'b0;
      err_q  <= 1'b0;
      ben_q  <= 2'b00;
      addr_q <= 32'h0;
      dat_q  <= 32'h0;
      rdat_q <= 32'h0;
      sel_q  <= 4'b0000;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (dmem.dmem_req_i) begin
          wren_q <= dmem.dmem_wren_i;
          usgn_q <= dmem.dmem_usgn_i;
          ben_q  <= dmem.dmem_ben_i;
          addr_q <= dmem.dmem_addr_i;
          sel_q  <= sel_d;
          dat_q  <= dat_d;
          err_q  <= misalign;
          rdat_q <= 32'h0;
          cnt_q  <= '0;
        end
        BUS: begin
          cnt_q <= cnt_q + CW'(1);
          // err beats ack, and either beats a timeout landing in the same cycle
          if (wb.wb_err_i) begin
            err_q <= 1'b1;
          end else if (wb.wb_ack_i) begin
            err_q  <= 1'b0;
            rdat_q <= wb.wb_dat_i;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  always_comb begin
    lane_b = 8'h0;
    case (addr_q[1:0])
      2'd0: lane_b = rdat_q[7:0];
      2'd1: lane_b = rdat_q[15:8];
      2'd2: lane_b = rdat_q[23:16];
      default: lane_b = rdat_q[31:24];
    endcase
    lane_h = addr_q[1] ? rdat_q[31:16] : rdat_q[15:0];
    case (ben_q)
      2'b00:   load_ext = {{24{~usgn_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~usgn_q & lane_h[15]}}, lane_h};
      default: load_ext = rdat_q;
    endcase
  end

  assign dmem.dmem_gnt_o   = (state_q == RESP);
  assign dmem.dmem_err_o   = (state_q == RESP) & err_q;
  assign dmem.dmem_rdata_o = ((state_q == RESP) && !err_q && !wren_q) ? load_ext : 32'h0;

  assign wb.wb_cyc_o = in_bus;
  assign wb.wb_stb_o = in_bus;
  assign wb.wb_we_o  = in_bus & wren_q;
  assign wb.wb_sel_o = in_bus ? sel_q : 4'b0000;
  assign wb.wb_adr_o = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign wb.wb_dat_o = in_bus ? dat_q : 32'h0;

endmodule

// File: tb/tb_harv_dmem_wb_bridge.sv
// Directed + randomized bench for harv_dmem_wb_bridge with TIMEOUT_CYCLES = 4,
// checked against an arithmetic reference of the access rules.
module tb_harv_dmem_wb_bridge;
  localparam int T = 4;

  logic clk;
  logic rstn;
  harv_dmem_if d();
  harv_wb_if   w();

  harv_dmem_wb_bridge #(.TIMEOUT_CYCLES(T)) u_dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .dmem   (d),
    .wb     (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int last_gnt = 0;
  int bus_start = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] ben, input logic us,
                                           input logic [31:0] addr, input logic [31:0] mem);
    int sh;
    logic [31:0] v;
    if (ben == 2'd0) begin
      sh = 8 * int'(addr % 4);
      v = (mem >> sh) & 32'hFF;
      if (!us && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (ben == 2'd1) begin
      sh = 8 * int'(addr & 32'd2);
      v = (mem >> sh) & 32'hFFFF;
      if (!us && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  // kind: 0 ack, 1 err, 2 ack+err together, 3 never respond
  task automatic access(input logic wr, input logic [1:0] ben, input logic us,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mem,
                        input int waits, input int kind, input bit use_x, input logic [31:0] xr);
    bit misal, timed;
    int resp_at;
    logic [3:0]  esel;
    logic [31:0] edat, erd;
    logic        eerr;
    misal = (ben == 2'd3) || (ben == 2'd1 && addr % 2 != 0) || (ben == 2'd2 && addr % 4 != 0);
    esel = 4'd0;
    edat = 32'd0;
    if (ben == 2'd0) begin
      esel = 4'(1 << (addr % 4));
      edat = (wdata & 32'hFF) * 32'h0101_0101;
    end else if (ben == 2'd1) begin
      esel = 4'(3 << (addr & 32'd2));
      edat = (wdata & 32'hFFFF) * 32'h0001_0001;
    end else if (ben == 2'd2) begin
      esel = 4'hF;
      edat = wdata;
    end

    d.dmem_req_i   = 1'b1;
    d.dmem_wren_i  = wr;
    d.dmem_ben_i   = ben;
    d.dmem_usgn_i  = us;
    d.dmem_addr_i  = addr;
    d.dmem_wdata_i = wdata;
    if (d.dmem_gnt_o === 1'b1) begin
      tick();
      chk("gnt_single_pulse", {31'd0, d.dmem_gnt_o}, 32'd0);
    end
    tick();

    if (misal) begin
      chk("misal_cyc", {31'd0, w.wb_cyc_o}, 32'd0);
      chk("misal_gnt", {31'd0, d.dmem_gnt_o}, 32'd1);
      chk("misal_err", {31'd0, d.dmem_err_o}, 32'd1);
      chk("misal_rdata", d.dmem_rdata_o, 32'd0);
      last_gnt = cyc_n;
      d.dmem_req_i = 1'b0;
      return;
    end

    timed   = (kind == 3) || (waits > T);
    resp_at = timed ? T : waits;
    bus_start = cyc_n;
    for (int k = 0; k <= resp_at; k++) begin
      chk("bus_cyc", {31'd0, w.wb_cyc_o}, 32'd1);
      chk("bus_stb", {31'd0, w.wb_stb_o}, 32'd1);
      chk("bus_we", {31'd0, w.wb_we_o}, {31'd0, wr});
      chk("bus_adr", w.wb_adr_o, addr & 32'hFFFF_FFFC);
      chk("bus_sel", {28'd0, w.wb_sel_o}, {28'd0, esel});
      chk("bus_dat_o", w.wb_dat_o, edat);
      chk("bus_no_gnt", {31'd0, d.dmem_gnt_o}, 32'd0);
      if (!timed && k == resp_at) begin
        w.wb_ack_i = (kind != 1);
        w.wb_err_i = (kind != 0);
        w.wb_dat_i = mem;
      end else begin
        w.wb_ack_i = 1'b0;
        w.wb_err_i = 1'b0;
        w.wb_dat_i = $urandom;
      end
      tick();
    end
    w.wb_ack_i = 1'b0;
    w.wb_err_i = 1'b0;

    eerr = timed || (kind != 0);
    erd  = (eerr || wr) ? 32'd0 : (use_x ? xr : ref_load(ben, us, addr, mem));
    chk("resp_gnt", {31'd0, d.dmem_gnt_o}, 32'd1);
    chk("resp_err", {31'd0, d.dmem_err_o}, {31'd0, eerr});
    chk("resp_rdata", d.dmem_rdata_o, erd);
    chk("resp_cyc_low", {31'd0, w.wb_cyc_o}, 32'd0);
    last_gnt = cyc_n;
    d.dmem_req_i = 1'b0;
  endtask

  initial begin
    int g;
    int r;
    logic [1:0]  rb;
    logic [31:0] ra;
    d.dmem_req_i = 0; d.dmem_wren_i = 0; d.dmem_ben_i = 0; d.dmem_usgn_i = 0;
    d.dmem_addr_i = 0; d.dmem_wdata_i = 0;
    w.wb_dat_i = 0; w.wb_ack_i = 0; w.wb_err_i = 0;
    rstn = 1'b0;
    tick();
    tick();
    chk("rst_cyc", {31'd0, w.wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, w.wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, w.wb_we_o}, 32'd0);
    chk("rst_sel", {28'd0, w.wb_sel_o}, 32'd0);
    chk("rst_adr", w.wb_adr_o, 32'd0);
    chk("rst_dat_o", w.wb_dat_o, 32'd0);
    chk("rst_gnt", {31'd0, d.dmem_gnt_o}, 32'd0);
    chk("rst_err", {31'd0, d.dmem_err_o}, 32'd0);
    chk("rst_rdata", d.dmem_rdata_o, 32'd0);
    rstn = 1'b1;
    tick();

    // zero-wait word load: gnt two cycles after the sample
    access(0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF);
    chk("zw_latency", 32'(last_gnt - bus_start), 32'd1);
    access(1, 2'd0, 0, 32'h103, 32'h0000_00A5, 32'h1234_5678, 0, 0, 0, 32'h0);
    access(0, 2'd0, 0, 32'h102, 32'h0, 32'h80F1_7F00, 1, 0, 1, 32'hFFFF_FFF1);
    access(0, 2'd0, 1, 32'h102, 32'h0, 32'h80F1_7F00, 0, 0, 1, 32'h0000_00F1);
    access(0, 2'd1, 0, 32'h102, 32'h0, 32'h80F1_7F00, 2, 0, 1, 32'hFFFF_80F1);
    access(1, 2'd1, 0, 32'h102, 32'h0000_BEEF, 32'h0, 1, 0, 0, 32'h0);

    access(0, 2'd1, 0, 32'h101, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    access(1, 2'd2, 0, 32'h102, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    access(0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0, 0, 0, 32'h0);

    access(0, 2'd2, 0, 32'h200, 32'h0, 32'h0, 0, 3, 0, 32'h0);
    chk("timeout_cyc_span", 32'(last_gnt - bus_start), 32'(T + 1));
    access(0, 2'd2, 0, 32'h204, 32'h0, 32'h5555_AAAA, 1, 2, 0, 32'h0);
    access(0, 2'd2, 0, 32'h208, 32'h0, 32'h1357_9BDF, T, 0, 1, 32'h1357_9BDF);
    access(1, 2'd2, 0, 32'h20C, 32'hCAFE_F00D, 32'h0, 2, 1, 0, 32'h0);

    // three wait states, then a request held right after gnt
    access(0, 2'd2, 0, 32'h300, 32'h0, 32'h0BAD_F00D, 3, 0, 1, 32'h0BAD_F00D);
    g = last_gnt;
    access(1, 2'd0, 0, 32'h301, 32'h0000_0077, 32'h0, 0, 0, 0, 32'h0);
    chk("b2b_gap", 32'(bus_start - g), 32'd2);

    // reset while the bus cycle is open
    d.dmem_req_i = 1'b1; d.dmem_wren_i = 1'b0; d.dmem_ben_i = 2'd2;
    d.dmem_addr_i = 32'h400; d.dmem_usgn_i = 1'b0;
    if (d.dmem_gnt_o === 1'b1) tick();
    tick();
    chk("rstmid_cyc_before", {31'd0, w.wb_cyc_o}, 32'd1);
    tick();
    rstn = 1'b0;
    tick();
    chk("rstmid_cyc", {31'd0, w.wb_cyc_o}, 32'd0);
    chk("rstmid_gnt", {31'd0, d.dmem_gnt_o}, 32'd0);
    d.dmem_req_i = 1'b0;
    tick();
    chk("rstmid_gnt2", {31'd0, d.dmem_gnt_o}, 32'd0);
    rstn = 1'b1;
    tick();
    chk("rstmid_gnt3", {31'd0, d.dmem_gnt_o}, 32'd0);
    chk("rstmid_cyc3", {31'd0, w.wb_cyc_o}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom_range(0, 9));
      rb = (r == 9) ? 2'd3 : 2'(r % 3);
      ra = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (rb == 2'd1) ra[0] = 1'b0;
        if (rb == 2'd2) ra[1:0] = 2'b00;
      end
      r = int'($urandom_range(0, 9));
      access(1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)), ra, $urandom, $urandom,
             int'($urandom_range(0, 3)), (r < 7) ? 0 : (r < 9) ? 1 : 3, 0, 32'h0);
    end
    tick();
    chk("final_gnt_low", {31'd0, d.dmem_gnt_o}, 32'd0);
    chk("final_cyc_low", {31'd0, w.wb_cyc_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
